// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - four-channel push-button debouncer with press/release pulses
module btn_debounce #(
  parameter int STABLE_CYCLES = 100000,
  parameter int CNT_W         = 17
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [3:0] btn_raw_i,
  output logic [3:0] btn_o,
  output logic [3:0] btn_press_o,
  output logic [3:0] btn_release_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [3:0]       s1;
  logic [3:0]       s2;
  logic [CNT_W-1:0] cnt [4];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1            <= '0;
      s2            <= '0;
      btn_o         <= '0;
      btn_press_o   <= '0;
      btn_release_o <= '0;
      for (int i = 0; i < 4; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1 <= btn_raw_i;
      s2 <= s1;
      for (int i = 0; i < 4; i++) begin
        btn_press_o[i]   <= 1'b0;
        btn_release_o[i] <= 1'b0;
        // Any return to the accepted level discards the partial count.
        if (s2[i] == btn_o[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          btn_o[i]         <= s2[i];
          cnt[i]           <= '0;
          btn_press_o[i]   <= s2[i];
          btn_release_o[i] <= ~s2[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// tb/tb_btn_debounce.sv - scoreboard bench for btn_debounce with STABLE_CYCLES=4
module tb_btn_debounce;

  localparam int S   = 4;
  localparam int LAT = S + 1;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] btn_raw_i = 4'h0;
  logic [3:0] btn_o;
  logic [3:0] btn_press_o;
  logic [3:0] btn_release_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic [3:0] raw;
    logic [3:0] btn;
    logic [3:0] press;
    logic [3:0] rel;
  } vec_t;

  vec_t sb[$];

  btn_debounce #(.STABLE_CYCLES(S), .CNT_W(3)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .btn_raw_i     (btn_raw_i),
    .btn_o         (btn_o),
    .btn_press_o   (btn_press_o),
    .btn_release_o (btn_release_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic push(input logic rst, input logic [3:0] raw,
                      input logic [3:0] btn, input logic [3:0] press, input logic [3:0] rel);
    vec_t v;
    v.rst = rst; v.raw = raw; v.btn = btn; v.press = press; v.rel = rel;
    sb.push_back(v);
  endtask

  task automatic do_reset();
    rst_i     = 1'b1;
    btn_raw_i = 4'h0;
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    vec_t v;
    int   k;
    for (int i = 0; i < 3; i++) push(1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
    for (int i = 0; i < 8; i++)
      push(1'b0, 4'hF, (i >= LAT) ? 4'hF : 4'h0, (i == LAT) ? 4'hF : 4'h0, 4'h0);
    k = 0;
    while (sb.size() > 0) begin
      v = sb.pop_front();
      rst_i = v.rst; btn_raw_i = v.raw;
      @(posedge clk_i); #1;
      total++; if (btn_o !== v.btn) begin bad++; $display("FAIL reset btn_o step %0d got=%h exp=%h", k, btn_o, v.btn); end
      total++; if (btn_press_o !== v.press) begin bad++; $display("FAIL reset press step %0d got=%h exp=%h", k, btn_press_o, v.press); end
      total++; if (btn_release_o !== v.rel) begin bad++; $display("FAIL reset release step %0d got=%h exp=%h", k, btn_release_o, v.rel); end
      k++;
    end
  endtask

  task automatic test_press();
    vec_t v;
    int   k;
    do_reset();
    for (int i = 0; i < 9; i++)
      push(1'b0, 4'b0001, (i >= LAT) ? 4'b0001 : 4'h0, (i == LAT) ? 4'b0001 : 4'h0, 4'h0);
    k = 0;
    while (sb.size() > 0) begin
      v = sb.pop_front();
      rst_i = v.rst; btn_raw_i = v.raw;
      @(posedge clk_i); #1;
      total++; if (btn_o !== v.btn) begin bad++; $display("FAIL press btn_o step %0d got=%h exp=%h", k, btn_o, v.btn); end
      total++; if (btn_press_o !== v.press) begin bad++; $display("FAIL press press step %0d got=%h exp=%h", k, btn_press_o, v.press); end
      total++; if (btn_release_o !== v.rel) begin bad++; $display("FAIL press release step %0d got=%h exp=%h", k, btn_release_o, v.rel); end
      k++;
    end
  endtask

  task automatic test_bounce();
    vec_t       v;
    int         k;
    logic [3:0] raw;
    do_reset();
    // raw[1] goes 1,0,1,0 then holds 1 from step 4
    for (int i = 0; i < 13; i++) begin
      raw = (i >= 4 || i == 0 || i == 2) ? 4'b0010 : 4'b0000;
      push(1'b0, raw, (i >= 4 + LAT) ? 4'b0010 : 4'h0, (i == 4 + LAT) ? 4'b0010 : 4'h0, 4'h0);
    end
    k = 0;
    while (sb.size() > 0) begin
      v = sb.pop_front();
      rst_i = v.rst; btn_raw_i = v.raw;
      @(posedge clk_i); #1;
      total++; if (btn_o !== v.btn) begin bad++; $display("FAIL bounce btn_o step %0d got=%h exp=%h", k, btn_o, v.btn); end
      total++; if (btn_press_o !== v.press) begin bad++; $display("FAIL bounce press step %0d got=%h exp=%h", k, btn_press_o, v.press); end
      total++; if (btn_release_o !== v.rel) begin bad++; $display("FAIL bounce release step %0d got=%h exp=%h", k, btn_release_o, v.rel); end
      k++;
    end
  endtask

  task automatic test_glitch();
    vec_t v;
    int   k;
    do_reset();
    for (int i = 0; i < 11; i++)
      push(1'b0, (i < 3) ? 4'b0100 : 4'h0, 4'h0, 4'h0, 4'h0);
    k = 0;
    while (sb.size() > 0) begin
      v = sb.pop_front();
      rst_i = v.rst; btn_raw_i = v.raw;
      @(posedge clk_i); #1;
      total++; if (btn_o !== v.btn) begin bad++; $display("FAIL glitch btn_o step %0d got=%h exp=%h", k, btn_o, v.btn); end
      total++; if (btn_press_o !== v.press) begin bad++; $display("FAIL glitch press step %0d got=%h exp=%h", k, btn_press_o, v.press); end
      total++; if (btn_release_o !== v.rel) begin bad++; $display("FAIL glitch release step %0d got=%h exp=%h", k, btn_release_o, v.rel); end
      k++;
    end
  endtask

  task automatic test_simultaneous();
    vec_t v;
    int   k;
    do_reset();
    for (int i = 0; i < 8; i++)
      push(1'b0, 4'b0001, (i >= LAT) ? 4'b0001 : 4'h0, (i == LAT) ? 4'b0001 : 4'h0, 4'h0);
    // channel 0 releases while channel 3 presses on the same edge
    for (int i = 0; i < 9; i++)
      push(1'b0, 4'b1000, (i >= LAT) ? 4'b1000 : 4'b0001,
           (i == LAT) ? 4'b1000 : 4'h0, (i == LAT) ? 4'b0001 : 4'h0);
    k = 0;
    while (sb.size() > 0) begin
      v = sb.pop_front();
      rst_i = v.rst; btn_raw_i = v.raw;
      @(posedge clk_i); #1;
      total++; if (btn_o !== v.btn) begin bad++; $display("FAIL simul btn_o step %0d got=%h exp=%h", k, btn_o, v.btn); end
      total++; if (btn_press_o !== v.press) begin bad++; $display("FAIL simul press step %0d got=%h exp=%h", k, btn_press_o, v.press); end
      total++; if (btn_release_o !== v.rel) begin bad++; $display("FAIL simul release step %0d got=%h exp=%h", k, btn_release_o, v.rel); end
      k++;
    end
  endtask

  task automatic test_reset_mid();
    vec_t v;
    int   k;
    do_reset();
    // counter reaches 2 after step 3; reset at step 4; first free edge is step 5
    for (int i = 0; i < 13; i++)
      push((i == 4) ? 1'b1 : 1'b0, 4'b0001, (i >= 5 + LAT) ? 4'b0001 : 4'h0,
           (i == 5 + LAT) ? 4'b0001 : 4'h0, 4'h0);
    k = 0;
    while (sb.size() > 0) begin
      v = sb.pop_front();
      rst_i = v.rst; btn_raw_i = v.raw;
      @(posedge clk_i); #1;
      total++; if (btn_o !== v.btn) begin bad++; $display("FAIL rstmid btn_o step %0d got=%h exp=%h", k, btn_o, v.btn); end
      total++; if (btn_press_o !== v.press) begin bad++; $display("FAIL rstmid press step %0d got=%h exp=%h", k, btn_press_o, v.press); end
      total++; if (btn_release_o !== v.rel) begin bad++; $display("FAIL rstmid release step %0d got=%h exp=%h", k, btn_release_o, v.rel); end
      k++;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 100000, meaning the consecutive synchronized cycles a new level must persist before acceptance (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter CNT_W, default 17, meaning the counter width; CNT_W SHALL be at least clog2(STABLE_CYCLES).
REQ-003 SHALL have port clk_i  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port btn_raw_i  input  4  raw, asynchronous, bouncing push-button levels from the board pins.
REQ-006 SHALL have port btn_o  output  4  debounced button levels; this port feeds the button input of the downstream lab2 logic.
REQ-007 SHALL have port btn_press_o  output  4  one-cycle pulse per channel on each accepted 0->1 transition.
REQ-008 SHALL have port btn_release_o  output  4  one-cycle pulse per channel on each accepted 1->0 transition.

Function
REQ-009 SHALL pass each btn_raw_i bit through its own two-flop synchronizer (s1, s2) before any other use.
REQ-010 SHALL process the four channels fully independently: each channel has its own synchronizer, its own CNT_W-bit counter and its own btn_o bit, and has no cross-channel interaction.
REQ-011 When a channel's s2 equals its btn_o bit, the channel SHALL clear its counter to 0 at the next edge.
REQ-012 When s2 differs from btn_o and the counter is below STABLE_CYCLES-1, the channel SHALL increment the counter by 1.
REQ-013 When s2 differs from btn_o and the counter equals STABLE_CYCLES-1, the channel SHALL at that edge load btn_o with s2 and clear the counter to 0.
REQ-014 At the same edge as REQ-013, the channel SHALL assert btn_press_o (0->1) or btn_release_o (1->0) for exactly one cycle.
REQ-015 Latency: a raw level first sampled at edge E and held stable SHALL appear on btn_o at edge E+STABLE_CYCLES+1.
REQ-016 Any raw pulse or glitch shorter than STABLE_CYCLES synchronized cycles SHALL leave btn_o, btn_press_o and btn_release_o unchanged, and SHALL restart the count from 0.
REQ-017 btn_press_o and btn_release_o SHALL never both be high on the same channel, and neither SHALL be high for two consecutive cycles.
REQ-018 Several channels qualifying on the same edge SHALL each update and pulse on that same edge.
REQ-019 The counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-020 All outputs SHALL be registered; there SHALL be no combinational path from btn_raw_i to any output.

Reset
REQ-021 While rst_i is high at an edge, the block SHALL clear s1, s2, all counters, btn_o, btn_press_o and btn_release_o to 0.
REQ-022 rst_i SHALL take priority over every other update, including a qualifying transition on the same edge.
REQ-023 A reset that arrives mid-count SHALL discard the partial count.
REQ-024 If a button is held high through reset, the block SHALL re-debounce it after reset release, and SHALL issue a btn_press_o pulse when it is accepted.

Verification (bench uses STABLE_CYCLES=4)
REQ-025 The bench SHALL cover reset: rst_i high 3 cycles with btn_raw_i=4'hF -> btn_o=0, press=0, release=0 throughout; btn_o=4'hF at the 6th edge after release, with press_o=4'hF for 1 cycle.
REQ-026 The bench SHALL cover a clean press: btn_raw_i 0->4'b0001 from edge E -> btn_o[0]=1 and btn_press_o=4'b0001 at edge E+5 only.
REQ-027 The bench SHALL cover a bounce: btn_raw_i[1] toggles 1,0,1,0,1 on successive cycles, then holds 1 -> no output change during bouncing; btn_o[1] rises 5 edges after the final 0->1.
REQ-028 The bench SHALL cover a glitch: btn_raw_i[2]=1 for 3 cycles, then 0 -> btn_o stays 4'h0 and no pulses occur.
REQ-029 The bench SHALL cover a release plus a simultaneous event: channels 0 and 3 change opposite directions on the same edge E -> btn_o[0] and btn_o[3] both update at edge E+5, with release_o[0]=1 and press_o[3]=1 for 1 cycle.
REQ-030 The bench SHALL cover reset mid-count: rst_i pulsed 1 cycle at count 2 with raw held 1 -> btn_o stays 0 until 6 edges after rst_i falls.
